// File: rtl/core_run_monitor.sv
// Run controller and retirement monitor for the single-cycle core: sequences the
// core reset, drives the switch stimulus, counts cycles/retirements, detects halt/timeout.
module core_run_monitor #(
  parameter int PC_W           = 32,
  parameter int CNT_W          = 32,
  parameter int SW_W           = 32,
  parameter int RST_CYCLES     = 2,
  parameter int HALT_REPEAT    = 4,
  parameter int TIMEOUT_CYCLES = 100,
  parameter logic [SW_W-1:0] SW_IDLE = '0,
  parameter logic [SW_W-1:0] SW_STIM = SW_W'(32'hDEADBEEF)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_restart,
  input  logic [PC_W-1:0]  i_pc_debug,
  input  logic             i_insn_vld,
  output logic             o_core_rst_n,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_retired_cnt,
  output logic             o_halt,
  output logic             o_timeout,
  output logic             o_done
);

  // state | meaning
  // HOLD  | core held in reset, hold counter running
  // RUN   | core released, counting cycles and retirements
  // DONE  | halt or timeout seen, counters frozen until restart
  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int REP_W  = $clog2(HALT_REPEAT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             halt_q, halt_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic [SW_W-1:0]  io_sw_q, io_sw_d;
  logic [REP_W-1:0] rep_upd;

  // rep_q == 0 marks an empty tracker, so the first valid after HOLD always loads
  assign rep_upd = ((rep_q != '0) && (i_pc_debug == last_pc_q)) ? rep_q + 1'b1 : REP_W'(1);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;
    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    halt_d    = halt_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    if (i_restart) begin
      state_d   = ST_HOLD;
      hold_d    = '0;
      cycle_d   = '0;
      retired_d = '0;
      last_pc_d = '0;
      rep_d     = '0;
      halt_d    = 1'b0;
      timeout_d = 1'b0;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RUN: begin
          cycle_d = cycle_q + 1'b1;
          if (i_insn_vld) begin
            retired_d = retired_q + 1'b1;
            last_pc_d = i_pc_debug;
            rep_d     = rep_upd;
          end
          // halt outranks a timeout landing on the same clock
          if (i_insn_vld && (rep_upd == REP_MAX)) begin
            halt_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (cycle_q == TO_LAST) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end
        end
        default: ;
      endcase
    end
    core_rst_n_d = (state_d != ST_HOLD);
    io_sw_d      = (state_d == ST_HOLD) ? SW_IDLE : SW_STIM;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_HOLD;
      hold_q       <= '0;
      cycle_q      <= '0;
      retired_q    <= '0;
      last_pc_q    <= '0;
      rep_q        <= '0;
      halt_q       <= 1'b0;
      timeout_q    <= 1'b0;
      done_q       <= 1'b0;
      core_rst_n_q <= 1'b0;
      io_sw_q      <= SW_IDLE;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cycle_q      <= cycle_d;
      retired_q    <= retired_d;
      last_pc_q    <= last_pc_d;
      rep_q        <= rep_d;
      halt_q       <= halt_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
      core_rst_n_q <= core_rst_n_d;
      io_sw_q      <= io_sw_d;
    end
  end

  assign o_core_rst_n  = core_rst_n_q;
  assign o_io_sw       = io_sw_q;
  assign o_cycle_cnt   = cycle_q;
  assign o_retired_cnt = retired_q;
  assign o_halt        = halt_q;
  assign o_timeout     = timeout_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// Bench for core_run_monitor: directed and random runs against a history-based reference model.
module tb_core_run_monitor;
  localparam int RSTC = 2;
  localparam int HREP = 4;
  localparam int TOUT = 100;
  localparam logic [31:0] STIM = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] pc = '0;
  logic        vld = 1'b0;
  logic        core_rst_n;
  logic [31:0] io_sw;
  logic [31:0] cyc, ret;
  logic        halt, tmo, done;

  int tests = 0;
  int fails = 0;

  core_run_monitor dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart), .i_pc_debug(pc), .i_insn_vld(vld),
    .o_core_rst_n(core_rst_n), .o_io_sw(io_sw), .o_cycle_cnt(cyc), .o_retired_cnt(ret),
    .o_halt(halt), .o_timeout(tmo), .o_done(done)
  );

  always #5 clk = ~clk;

  // reference model: phase 0=held, 1=running, 2=finished
  int          m_phase, m_hold_edges, m_cycles, m_retired;
  bit          m_halt, m_tmo;
  logic [31:0] m_pcs[$];

  task automatic m_clear();
    m_phase = 0; m_hold_edges = 0; m_cycles = 0; m_retired = 0;
    m_halt = 0; m_tmo = 0; m_pcs.delete();
  endtask

  task automatic m_edge(input logic r, input logic [31:0] p, input logic v);
    bit same;
    int sz;
    if (r) begin
      m_clear();
      return;
    end
    if (m_phase == 0) begin
      m_hold_edges++;
      if (m_hold_edges == RSTC) m_phase = 1;
    end else if (m_phase == 1) begin
      m_cycles++;
      same = 0;
      if (v) begin
        m_retired++;
        m_pcs.push_back(p);
        sz = m_pcs.size();
        if (sz >= HREP) begin
          same = 1;
          for (int k = 1; k < HREP; k++)
            if (m_pcs[sz-1-k] != m_pcs[sz-1]) same = 0;
        end
      end
      if (same) begin
        m_halt = 1; m_phase = 2;
      end else if (m_cycles == TOUT) begin
        m_tmo = 1; m_phase = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("core_rst_n", 64'(core_rst_n), 64'(m_phase != 0));
    chk("io_sw", 64'(io_sw), (m_phase == 0) ? 64'h0 : 64'(STIM));
    chk("cycle_cnt", 64'(cyc), 64'(m_cycles));
    chk("retired_cnt", 64'(ret), 64'(m_retired));
    chk("halt", 64'(halt), 64'(m_halt));
    chk("timeout", 64'(tmo), 64'(m_tmo));
    chk("done", 64'(done), 64'(m_halt | m_tmo));
  endtask

  // called at a negedge; returns at the next negedge
  task automatic step(input logic r, input logic [31:0] p, input logic v);
    restart = r; pc = p; vld = v;
    @(posedge clk);
    m_edge(r, p, v);
    #1 check_all();
    @(negedge clk);
  endtask

  logic [31:0] pcset[3];

  initial begin
    pcset[0] = 32'h0; pcset[1] = 32'h4; pcset[2] = 32'h8;
    m_clear();
    #2 check_all();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // reset release: low after 1 edge, high after the 2nd
    step(0, 0, 0);
    chk("rel_edge1", 64'(core_rst_n), 64'h0);
    step(0, 0, 0);
    chk("rel_edge2", 64'(core_rst_n), 64'h1);
    chk("rel_sw", 64'(io_sw), 64'hDEADBEEF);

    // straight-line retire to timeout
    for (int i = 0; i < 110; i++) step(0, 32'(4 * i), 1);
    chk("st_cycle", 64'(cyc), 64'd100);
    chk("st_ret", 64'(ret), 64'd100);
    chk("st_tmo", 64'({halt, tmo, done}), 64'b011);

    // restart in DONE, then self-loop halt
    step(1, 0, 0);
    chk("rs_clear", 64'({core_rst_n, halt, tmo, done}), 64'h0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 32'h0, 1); step(0, 32'h4, 1); step(0, 32'h8, 1);
    for (int i = 0; i < 4; i++) step(0, 32'hC, 1);
    chk("sl_halt", 64'({halt, tmo, done}), 64'b101);
    chk("sl_ret", 64'(ret), 64'd7);
    for (int i = 0; i < 20; i++) step(0, $urandom, 1'($urandom));
    chk("sl_frozen", 64'(ret), 64'd7);

    // restart mid-RUN, then restart again during HOLD
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 32'(i), 1);
    step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("hold_restart", 64'(core_rst_n), 64'h0);
    step(0, 0, 0);

    // invalid gaps and a different PC mid-sequence
    step(0, 32'hC, 1); step(0, 32'hC, 1); step(0, 32'h10, 1);
    step(0, 32'hC, 1); step(0, 32'hC, 0); step(0, 32'hC, 1);
    step(0, 32'hC, 0); step(0, 32'hC, 1);
    chk("gap_nohalt", 64'(halt), 64'h0);
    step(0, 32'hC, 1);
    chk("gap_halt", 64'({halt, done}), 64'b11);
    chk("gap_ret", 64'(ret), 64'd7);

    // halt and timeout on the same clock
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 1; i <= 96; i++) step(0, 32'(4 * i), 1);
    for (int i = 0; i < 4; i++) step(0, 32'h500, 1);
    chk("sim_flags", 64'({halt, tmo, done}), 64'b101);
    chk("sim_cycle", 64'(cyc), 64'd100);

    // randomized runs
    step(1, 0, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 39) == 0), pcset[$urandom_range(0, 2)], 1'($urandom));

    // asynchronous reset mid-RUN
    step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'(i), 1);
    #2 rst_n = 1'b0;
    #1 m_clear();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 32'h40, 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
